// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file and a parallel host port.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample filter on SCL/SDA.
module i2c_target_regfile #(
   parameter logic [6:0]  DEV_ADDR = 7'h50,
   parameter int unsigned NUM_REGS = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        scl_i,
   input  logic                        sda_i,
   output logic                        sda_oe_o,
   input  logic [$clog2(NUM_REGS)-1:0] reg_addr_i,
   input  logic                        reg_we_i,
   input  logic [7:0]                  reg_wdata_i,
   output logic [7:0]                  reg_rdata_o,
   output logic                        wr_evt_o,
   output logic [$clog2(NUM_REGS)-1:0] wr_evt_addr_o,
   output logic                        busy_o
);
   localparam int unsigned AW = $clog2(NUM_REGS);

   typedef enum logic [3:0] {
      StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
      StWrData, StWrAck, StRdData, StRdMack, StWait
   } state_e;

   logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q, scl_prev_q, sda_prev_q;
   logic scl_f, sda_f;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_s1_q   <= 1'b1;
         scl_s2_q   <= 1'b1;
         sda_s1_q   <= 1'b1;
         sda_s2_q   <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_s1_q   <= scl_i;
         scl_s2_q   <= scl_s1_q;
         sda_s1_q   <= sda_i;
         sda_s2_q   <= sda_s1_q;
         scl_prev_q <= scl_f;
         sda_prev_q <= sda_f;
      end
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [1:0] scl_h_q, sda_h_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_h_q <= 2'b11;
         sda_h_q <= 2'b11;
      end else begin
         scl_h_q <= {scl_h_q[0], scl_s2_q};
         sda_h_q <= {sda_h_q[0], sda_s2_q};
      end
   end

   // The previous filtered value doubles as the hold value until 3 samples agree.
   assign scl_f = (scl_s2_q == scl_h_q[0] && scl_h_q[0] == scl_h_q[1]) ? scl_s2_q : scl_prev_q;
   assign sda_f = (sda_s2_q == sda_h_q[0] && sda_h_q[0] == sda_h_q[1]) ? sda_s2_q : sda_prev_q;
`else
   assign scl_f = scl_s2_q;
   assign sda_f = sda_s2_q;
`endif

   logic scl_rise, scl_fall, start_det, stop_det;
   assign scl_rise  = scl_f & ~scl_prev_q;
   assign scl_fall  = ~scl_f & scl_prev_q;
   assign start_det = scl_f & scl_prev_q & ~sda_f & sda_prev_q;
   assign stop_det  = scl_f & scl_prev_q & sda_f & ~sda_prev_q;

   state_e          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [7:0]      sh_q, sh_d;
   logic [AW-1:0]   ptr_q, ptr_d, ptr_inc;
   logic            rw_q, rw_d, mack_q, mack_d, oe_q, oe_d, busy_q, busy_d, evt_q, evt_d;
   logic [AW-1:0]   evt_addr_q, evt_addr_d;
   logic [7:0]      rdata_q;
   logic [7:0]      regs_q [NUM_REGS];
   logic [7:0]      regs_d [NUM_REGS];
   logic [7:0]      rx_byte;

   assign rx_byte = {sh_q[6:0], sda_f};
   assign ptr_inc = ptr_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      ptr_d      = ptr_q;
      rw_d       = rw_q;
      mack_d     = mack_q;
      oe_d       = oe_q;
      busy_d     = busy_q;
      evt_d      = 1'b0;
      evt_addr_d = evt_addr_q;
      regs_d     = regs_q;
      if (reg_we_i) regs_d[reg_addr_i] = reg_wdata_i;
      // I2C commit below is assigned last so it wins a same-register collision.
      if (start_det) begin
         state_d = StAddr;
         cnt_d   = '0;
         oe_d    = 1'b0;
      end else if (stop_det) begin
         state_d = StIdle;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            StAddr: if (scl_rise) begin
               sh_d  = rx_byte;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                     state_d = StAddrAck;
                     rw_d    = rx_byte[0];
                     busy_d  = 1'b1;
                  end else begin
                     state_d = StIdle;
                     busy_d  = 1'b0;
                  end
               end
            end
            // First fall drives the ACK low, the second fall ends the ACK clock.
            StAddrAck, StPtrAck, StWrAck: if (scl_fall) begin
               cnt_d = '0;
               if (!oe_q) begin
                  oe_d = 1'b1;
               end else if (state_q == StAddrAck && rw_q) begin
                  sh_d    = regs_q[ptr_q];
                  oe_d    = ~regs_q[ptr_q][7];
                  state_d = StRdData;
               end else begin
                  oe_d    = 1'b0;
                  state_d = StWrData;
               end
            end
            StPtr: if (scl_rise) begin
               sh_d  = rx_byte;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  ptr_d   = rx_byte[AW-1:0];
                  state_d = StPtrAck;
               end
            end
            StWrData: if (scl_rise) begin
               sh_d  = rx_byte;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  regs_d[ptr_q] = rx_byte;
                  evt_d         = 1'b1;
                  evt_addr_d    = ptr_q;
                  ptr_d         = ptr_inc;
                  state_d       = StWrAck;
               end
            end
            StRdData: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     state_d = StRdMack;
                     mack_d  = 1'b0;
                  end
               end else if (scl_fall) begin
                  sh_d = {sh_q[6:0], 1'b0};
                  oe_d = ~sh_q[6];
               end
            end
            StRdMack: begin
               if (scl_rise) begin
                  if (sda_f) begin
                     state_d = StWait;
                  end else begin
                     ptr_d  = ptr_inc;
                     sh_d   = regs_q[ptr_inc];
                     mack_d = 1'b1;
                  end
               end else if (scl_fall) begin
                  if (mack_q) begin
                     oe_d    = ~sh_q[7];
                     cnt_d   = '0;
                     state_d = StRdData;
                  end else begin
                     oe_d = 1'b0;
                  end
               end
            end
            StIdle, StWait: ;
            default: state_d = StIdle;
         endcase
      end
      // The pointer phase follows the address ACK of a write.
      if (state_q == StAddrAck && state_d == StWrData) state_d = StPtr;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         sh_q       <= '0;
         ptr_q      <= '0;
         rw_q       <= 1'b0;
         mack_q     <= 1'b0;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
         evt_q      <= 1'b0;
         evt_addr_q <= '0;
         rdata_q    <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         ptr_q      <= ptr_d;
         rw_q       <= rw_d;
         mack_q     <= mack_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
         evt_q      <= evt_d;
         evt_addr_q <= evt_addr_d;
         rdata_q    <= regs_q[reg_addr_i];
         regs_q     <= regs_d;
      end
   end

   assign sda_oe_o      = oe_q;
   assign reg_rdata_o   = rdata_q;
   assign wr_evt_o      = evt_q;
   assign wr_evt_addr_o = evt_addr_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master plus a transaction-level register model.
module tb_i2c_target_regfile;
   localparam int unsigned N  = 16;
   localparam int unsigned AW = 4;
   localparam int          Q  = 8;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          m_scl = 1'b1, m_sda = 1'b1, glitch_n = 1'b1;
   logic          scl_w, sda_w, sda_oe;
   logic [AW-1:0] reg_addr = '0;
   logic          reg_we = 1'b0;
   logic [7:0]    reg_wdata = '0;
   logic [7:0]    reg_rdata;
   logic          wr_evt, busy;
   logic [AW-1:0] wr_evt_addr;

   assign scl_w = m_scl & glitch_n;
   assign sda_w = m_sda & ~sda_oe;

   i2c_target_regfile #(.DEV_ADDR(7'h50), .NUM_REGS(N)) dut (
      .clk_i(clk), .rst_i(rst), .scl_i(scl_w), .sda_i(sda_w), .sda_oe_o(sda_oe),
      .reg_addr_i(reg_addr), .reg_we_i(reg_we), .reg_wdata_i(reg_wdata),
      .reg_rdata_o(reg_rdata), .wr_evt_o(wr_evt), .wr_evt_addr_o(wr_evt_addr), .busy_o(busy)
   );

   int n_cmp = 0, n_bad = 0;
   logic [7:0] model [N];
   int mptr = 0;
   logic [7:0] wbuf [8];

   logic mon_en = 1'b0;
   int oe_cnt = 0, busy_cnt = 0, evt_cnt = 0;
   logic [AW-1:0] evt_log [256];

   always @(posedge clk) begin
      if (mon_en && sda_oe) oe_cnt <= oe_cnt + 1;
      if (mon_en && busy) busy_cnt <= busy_cnt + 1;
      if (wr_evt) begin
         evt_log[evt_cnt[7:0]] <= wr_evt_addr;
         evt_cnt <= evt_cnt + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(Q);
      m_sda = 1'b0; tick(Q);
      m_scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; tick(Q);
      m_scl = 1'b1; tick(Q);
      m_sda = 1'b1; tick(Q);
   endtask

   task automatic wbit(input logic b, input bit g);
      m_sda = b; tick(Q);
      m_scl = 1'b1;
      if (g) begin
         tick(4); glitch_n = 1'b0; tick(2); glitch_n = 1'b1; tick(2 * Q - 6);
      end else begin
         tick(2 * Q);
      end
      m_scl = 1'b0; tick(Q);
   endtask

   task automatic rbit(output logic b);
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(Q);
      b = sda_w; tick(Q);
      m_scl = 1'b0; tick(Q);
   endtask

   task automatic wbyte(input logic [7:0] d, input int gbit, output logic ack);
      for (int i = 7; i >= 0; i--) wbit(d[i], i == gbit);
      rbit(ack);
   endtask

   task automatic rbyte(output logic [7:0] d);
      for (int i = 7; i >= 0; i--) rbit(d[i]);
   endtask

   task automatic host_write(input int a, input logic [7:0] d);
      reg_addr = AW'(a); reg_wdata = d; reg_we = 1'b1; tick(1);
      reg_we = 1'b0;
      model[a] = d;
   endtask

   task automatic host_read(input int a, output logic [7:0] d);
      reg_addr = AW'(a); tick(1);
      d = reg_rdata;
   endtask

   // Byte sequence the target sees when one extra SCL rise repeats the bit at position pos.
   function automatic logic [7:0] glitched(input logic [7:0] d, input int pos);
      logic q[$];
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         q.push_back(d[7-i]);
         if (i == pos) q.push_back(d[7-i]);
      end
      for (int i = 0; i < 8; i++) r[7-i] = q[i];
      return r;
   endfunction

   // Write transaction: pointer p then n bytes from wbuf.
   task automatic xfer_write(input logic [7:0] p, input int n);
      logic ack;
      int e0 = evt_cnt;
      i2c_start();
      wbyte(8'hA0, -1, ack);
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL wr_addr_ack: got %b want 0", ack); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_set: got %b want 1", busy); end
      wbyte(p, -1, ack);
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL ptr_ack: got %b want 0", ack); end
      for (int k = 0; k < n; k++) begin
         wbyte(wbuf[k], -1, ack);
         n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL data_ack[%0d]: got %b want 0", k, ack); end
         model[(int'(p) + k) % N] = wbuf[k];
      end
      i2c_stop();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_clr: got %b want 0", busy); end
      n_cmp++;
      if (evt_cnt - e0 != n) begin n_bad++; $display("FAIL evt_count: got %0d want %0d", evt_cnt - e0, n); end
      for (int k = 0; k < n && k < evt_cnt - e0; k++) begin
         n_cmp++;
         if (int'(evt_log[(e0 + k) % 256]) != (int'(p) + k) % N) begin
            n_bad++;
            $display("FAIL evt_addr[%0d]: got %0d want %0d", k, evt_log[(e0 + k) % 256], (int'(p) + k) % N);
         end
      end
      mptr = (int'(p) + n) % N;
   endtask

   // Pointer write, repeated START, read n bytes (ACK all but the last), STOP.
   task automatic xfer_read(input logic [7:0] p, input int n);
      logic ack;
      logic [7:0] d;
      int o0;
      i2c_start();
      wbyte(8'hA0, -1, ack);
      wbyte(p, -1, ack);
      mptr = int'(p) % N;
      i2c_start();
      wbyte(8'hA1, -1, ack);
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
      for (int k = 0; k < n; k++) begin
         rbyte(d);
         n_cmp++;
         if (d !== model[(mptr + k) % N]) begin
            n_bad++;
            $display("FAIL rd_data[%0d]: got %h want %h", k, d, model[(mptr + k) % N]);
         end
         if (k == n - 1) begin
            o0 = oe_cnt; mon_en = 1'b1;
            wbit(1'b1, 1'b0);
            i2c_stop();
            mon_en = 1'b0; tick(1);
            n_cmp++;
            if (oe_cnt != o0) begin n_bad++; $display("FAIL nack_release: got %0d oe cycles want 0", oe_cnt - o0); end
         end else begin
            wbit(1'b0, 1'b0);
         end
      end
      mptr = (mptr + n - 1) % N;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      rst = 1'b1; tick(3);
      rst = 1'b0; tick(1);
      n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL rst_oe: got %b want 0", sda_oe); end
      n_cmp++; if (wr_evt !== 1'b0) begin n_bad++; $display("FAIL rst_evt: got %b want 0", wr_evt); end
      n_cmp++; if (wr_evt_addr !== '0) begin n_bad++; $display("FAIL rst_evt_addr: got %0d want 0", wr_evt_addr); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (reg_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata: got %h want 00", reg_rdata); end
      for (int i = 0; i < 3; i++) begin
         int a = $urandom_range(0, N - 1);
         host_read(a, d);
         n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rst_reg[%0d]: got %h want 00", a, d); end
      end
   endtask

   task automatic test_write_basic();
      logic [7:0] d;
      wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
      xfer_write(8'h03, 2);
      host_read(3, d);
      n_cmp++; if (d !== 8'hA5) begin n_bad++; $display("FAIL host_rd3: got %h want a5", d); end
      host_read(4, d);
      n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL host_rd4: got %h want 5a", d); end
   endtask

   task automatic test_wrap_read();
      host_write(15, 8'($urandom));
      host_write(0, 8'($urandom));
      host_write(1, 8'($urandom));
      xfer_read(8'h0F, 3);
   endtask

   task automatic test_addr_mismatch();
      logic ack;
      int o0 = oe_cnt, b0 = busy_cnt, e0 = evt_cnt;
      mon_en = 1'b1;
      i2c_start();
      wbyte(8'hA2, -1, ack);
      wbyte(8'h3C, -1, ack);
      i2c_stop();
      mon_en = 1'b0; tick(1);
      n_cmp++; if (ack !== 1'b1) begin n_bad++; $display("FAIL nomatch_ack: got %b want 1", ack); end
      n_cmp++; if (oe_cnt != o0) begin n_bad++; $display("FAIL nomatch_oe: got %0d want 0", oe_cnt - o0); end
      n_cmp++; if (busy_cnt != b0) begin n_bad++; $display("FAIL nomatch_busy: got %0d want 0", busy_cnt - b0); end
      n_cmp++; if (evt_cnt != e0) begin n_bad++; $display("FAIL nomatch_evt: got %0d want 0", evt_cnt - e0); end
   endtask

   // hreg == commit register: I2C wins; otherwise both writes land.
   task automatic test_collision();
      logic ack;
      logic [7:0] d;
      bit hit;
      for (int c = 0; c < 2; c++) begin
         int hreg = (c == 0) ? 2 : 9;
         i2c_start();
         wbyte(8'hA0, -1, ack);
         wbyte(8'h02, -1, ack);
         hit = 1'b0;
         fork
            wbyte(8'h11, -1, ack);
            begin
               reg_addr = AW'(hreg); reg_wdata = 8'h77; reg_we = 1'b1;
               for (int t = 0; t < 2000 && !hit; t++) begin
                  tick(1);
                  if (wr_evt) hit = 1'b1;
               end
               reg_we = 1'b0;
            end
         join
         i2c_stop();
         n_cmp++; if (!hit) begin n_bad++; $display("FAIL coll_evt_timeout: got none want 1"); end
         model[hreg] = 8'h77;
         model[2] = 8'h11;
         mptr = 3;
         host_read(2, d);
         n_cmp++; if (d !== model[2]) begin n_bad++; $display("FAIL coll_reg2: got %h want %h", d, model[2]); end
         host_read(hreg, d);
         n_cmp++;
         if (d !== model[hreg]) begin n_bad++; $display("FAIL coll_host[%0d]: got %h want %h", hreg, d, model[hreg]); end
      end
   endtask

   task automatic test_random();
      logic [7:0] d;
      for (int it = 0; it < 4; it++) begin
         logic [7:0] p = 8'($urandom);
         int n = $urandom_range(1, 3);
         for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
         xfer_write(p, n);
         for (int k = 0; k < n; k++) begin
            int a = (int'(p) + k) % N;
            host_read(a, d);
            n_cmp++; if (d !== model[a]) begin n_bad++; $display("FAIL rnd_host[%0d]: got %h want %h", a, d, model[a]); end
         end
         host_write($urandom_range(0, N - 1), 8'($urandom));
         xfer_read(p, n + 1);
      end
   endtask

   task automatic test_reset_midread();
      logic ack;
      logic [7:0] d;
      host_write(5, 8'h3C);
      i2c_start();
      wbyte(8'hA0, -1, ack);
      wbyte(8'h05, -1, ack);
      i2c_start();
      wbyte(8'hA1, -1, ack);
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(2);
      n_cmp++; if (sda_oe !== 1'b1) begin n_bad++; $display("FAIL midrd_drive: got %b want 1", sda_oe); end
      rst = 1'b1; tick(1);
      n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL midrd_oe: got %b want 0", sda_oe); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrd_busy: got %b want 0", busy); end
      rst = 1'b0;
      for (int i = 0; i < N; i++) model[i] = 8'h00;
      mptr = 0;
      tick(Q);
      host_read(5, d);
      n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL midrd_regclr: got %h want 00", d); end
      wbuf[0] = 8'($urandom);
      xfer_write(8'h06, 1);
      xfer_read(8'h06, 1);
   endtask

   task automatic test_glitch();
      logic ack;
      logic [7:0] d, exp;
      int e0 = evt_cnt;
      exp = FILT ? 8'hA5 : glitched(8'hA5, 2);
      i2c_start();
      wbyte(8'hA0, -1, ack);
      wbyte(8'h0A, -1, ack);
      wbyte(8'hA5, 5, ack);
      i2c_stop();
      model[10] = exp;
      mptr = 11;
      n_cmp++; if (evt_cnt - e0 != 1) begin n_bad++; $display("FAIL glitch_evts: got %0d want 1", evt_cnt - e0); end
      host_read(10, d);
      n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL glitch_data: got %h want %h", d, exp); end
   endtask

   initial begin
      for (int i = 0; i < N; i++) model[i] = 8'h00;
      test_reset();
      test_write_basic();
      test_wrap_read();
      test_addr_mismatch();
      test_collision();
      test_random();
      test_reset_midread();
      test_glitch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
